spi_master_xfer: RTL and testbench

- Parametrised full-duplex SPI master; the next generation of the team's 32-bit transmit-only SPI driver.
- Adds configurable word width, a generated serial clock with programmable divider, and selectable bit order.
- Adds MISO capture to a parallel output with a data_valid strobe, plus a busy flag.
- Sits between register/control logic and an external ADC/DAC-style peripheral, in SPI mode 0.

---
 rtl/spi_master_xfer.sv | 189 ++++++++++++++++++
 tb/tb_spi_master_xfer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_xfer.sv
// Full-duplex SPI master (mode 0): shifts one DATA_WIDTH word out on sdo while capturing sdi.
// Latency: frame lasts HALF_PERIOD*(2*DATA_WIDTH+2) cycles from the start edge to the data_valid pulse.
// Backpressure: none; send edges that arrive while a frame is in progress are dropped, not queued.
//
// Ports:
//   sclk, reset       system clock, synchronous active-high reset
//   send, pdi         start request (rising edge) and word to transmit
//   pdo, data_valid   received word and its one-cycle update strobe
//   busy              high for the whole frame
//   cs, spi_clk, sdo  serial outputs (cs active low, spi_clk idles low)
//   sdi               serial data in
module spi_master_xfer #(
    parameter int DATA_WIDTH  = 32,
    parameter int HALF_PERIOD = 2,
    parameter bit LSB_FIRST   = 1'b0
) (
    input  logic                  sclk,
    input  logic                  reset,
    input  logic                  send,
    input  logic [DATA_WIDTH-1:0] pdi,
    output logic [DATA_WIDTH-1:0] pdo,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  cs,
    output logic                  spi_clk,
    output logic                  sdo,
    input  logic                  sdi
);

    localparam int BCW = $clog2(DATA_WIDTH);
    localparam int HCW = 8;
    localparam logic [HCW-1:0] HP_RELOAD = HCW'(HALF_PERIOD - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [HCW-1:0]        hp_cnt, hp_cnt_nxt;
    logic [BCW-1:0]        bit_cnt, bit_cnt_nxt;
    logic [DATA_WIDTH-1:0] tx_sr, tx_sr_nxt;
    logic [DATA_WIDTH-1:0] rx_sr, rx_sr_nxt;
    logic [DATA_WIDTH-1:0] pdo_nxt;
    // Set on the final falling edge: the last bit still owns its low half
    // before HOLD, so the low-half end needs to know whether to rise again.
    logic                  last_done, last_done_nxt;
    logic                  send_q;
    logic                  cs_nxt, spi_clk_nxt, sdo_nxt, busy_nxt, data_valid_nxt;

    logic                  start;
    logic                  hp_done;
    logic [DATA_WIDTH-1:0] rx_shift_in;
    logic [DATA_WIDTH-1:0] tx_shifted;
    logic                  tx_next_bit;

    assign start   = (state == IDLE) && send && !send_q;
    assign hp_done = (hp_cnt == '0);

    always_comb begin
        if (LSB_FIRST) begin
            rx_shift_in = {sdi, rx_sr[DATA_WIDTH-1:1]};
            tx_shifted  = {1'b0, tx_sr[DATA_WIDTH-1:1]};
            tx_next_bit = tx_sr[1];
        end else begin
            rx_shift_in = {rx_sr[DATA_WIDTH-2:0], sdi};
            tx_shifted  = {tx_sr[DATA_WIDTH-2:0], 1'b0};
            tx_next_bit = tx_sr[DATA_WIDTH-2];
        end
    end

    always_comb begin
        state_nxt      = state;
        hp_cnt_nxt     = hp_cnt;
        bit_cnt_nxt    = bit_cnt;
        tx_sr_nxt      = tx_sr;
        rx_sr_nxt      = rx_sr;
        pdo_nxt        = pdo;
        last_done_nxt  = last_done;
        cs_nxt         = cs;
        spi_clk_nxt    = spi_clk;
        sdo_nxt        = sdo;
        busy_nxt       = busy;
        data_valid_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt     = SETUP;
                    hp_cnt_nxt    = HP_RELOAD;
                    bit_cnt_nxt   = BIT_LAST;
                    tx_sr_nxt     = pdi;
                    sdo_nxt       = LSB_FIRST ? pdi[0] : pdi[DATA_WIDTH-1];
                    last_done_nxt = 1'b0;
                    cs_nxt        = 1'b0;
                    busy_nxt      = 1'b1;
                end
            end

            SETUP: begin
                if (hp_done) begin
                    // First rising edge of spi_clk: capture bit 0.
                    state_nxt   = SHIFT;
                    hp_cnt_nxt  = HP_RELOAD;
                    spi_clk_nxt = 1'b1;
                    rx_sr_nxt   = rx_shift_in;
                end else begin
                    hp_cnt_nxt = hp_cnt - 1'b1;
                end
            end

            SHIFT: begin
                if (!hp_done) begin
                    hp_cnt_nxt = hp_cnt - 1'b1;
                end else begin
                    hp_cnt_nxt = HP_RELOAD;
                    if (spi_clk) begin
                        spi_clk_nxt = 1'b0;
                        if (bit_cnt == '0) begin
                            last_done_nxt = 1'b1;
                        end else begin
                            tx_sr_nxt   = tx_shifted;
                            sdo_nxt     = tx_next_bit;
                            bit_cnt_nxt = bit_cnt - 1'b1;
                        end
                    end else if (last_done) begin
                        state_nxt = HOLD;
                    end else begin
                        spi_clk_nxt = 1'b1;
                        rx_sr_nxt   = rx_shift_in;
                    end
                end
            end

            HOLD: begin
                if (hp_done) begin
                    state_nxt      = IDLE;
                    cs_nxt         = 1'b1;
                    busy_nxt       = 1'b0;
                    pdo_nxt        = rx_sr;
                    data_valid_nxt = 1'b1;
                    sdo_nxt        = 1'b0;
                end else begin
                    hp_cnt_nxt = hp_cnt - 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            state      <= IDLE;
            hp_cnt     <= '0;
            bit_cnt    <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            pdo        <= '0;
            last_done  <= 1'b0;
            send_q     <= 1'b0;
            cs         <= 1'b1;
            spi_clk    <= 1'b0;
            sdo        <= 1'b0;
            busy       <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            hp_cnt     <= hp_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            tx_sr      <= tx_sr_nxt;
            rx_sr      <= rx_sr_nxt;
            pdo        <= pdo_nxt;
            last_done  <= last_done_nxt;
            send_q     <= send;
            cs         <= cs_nxt;
            spi_clk    <= spi_clk_nxt;
            sdo        <= sdo_nxt;
            busy       <= busy_nxt;
            data_valid <= data_valid_nxt;
        end
    end

endmodule

// File: tb/tb_spi_master_xfer.sv
// Bench for spi_master_xfer: three configurations (8b MSB-first HP2, 32b HP1, 8b LSB-first HP3).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_spi_master_xfer;

    localparam int NK = 3;

    logic          sclk = 1'b0;
    logic          reset;
    logic [NK-1:0] send_v;
    logic [NK-1:0] loop_v;
    logic [NK-1:0] sdi_mdl;
    logic [NK-1:0] sdi_v;
    logic [NK-1:0] cs_v, sck_v, sdo_v, dv_v, busy_v;
    logic [7:0]    pdi0, pdo0, pdi2, pdo2;
    logic [31:0]   pdi1, pdo1;

    int checks = 0;
    int errors = 0;

    always #5 sclk = ~sclk;

    assign sdi_v[0] = loop_v[0] ? sdo_v[0] : sdi_mdl[0];
    assign sdi_v[1] = loop_v[1] ? sdo_v[1] : sdi_mdl[1];
    assign sdi_v[2] = loop_v[2] ? sdo_v[2] : sdi_mdl[2];

    spi_master_xfer #(.DATA_WIDTH(8), .HALF_PERIOD(2), .LSB_FIRST(1'b0)) u_msb8 (
        .sclk(sclk), .reset(reset), .send(send_v[0]), .pdi(pdi0), .pdo(pdo0),
        .data_valid(dv_v[0]), .busy(busy_v[0]), .cs(cs_v[0]), .spi_clk(sck_v[0]),
        .sdo(sdo_v[0]), .sdi(sdi_v[0]));

    spi_master_xfer #(.DATA_WIDTH(32), .HALF_PERIOD(1), .LSB_FIRST(1'b0)) u_msb32 (
        .sclk(sclk), .reset(reset), .send(send_v[1]), .pdi(pdi1), .pdo(pdo1),
        .data_valid(dv_v[1]), .busy(busy_v[1]), .cs(cs_v[1]), .spi_clk(sck_v[1]),
        .sdo(sdo_v[1]), .sdi(sdi_v[1]));

    spi_master_xfer #(.DATA_WIDTH(8), .HALF_PERIOD(3), .LSB_FIRST(1'b1)) u_lsb8 (
        .sclk(sclk), .reset(reset), .send(send_v[2]), .pdi(pdi2), .pdo(pdo2),
        .data_valid(dv_v[2]), .busy(busy_v[2]), .cs(cs_v[2]), .spi_clk(sck_v[2]),
        .sdo(sdo_v[2]), .sdi(sdi_v[2]));

    function automatic int dw_of(input int k);
        return (k == 1) ? 32 : 8;
    endfunction

    function automatic int hp_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic bit lsb_of(input int k);
        return (k == 2);
    endfunction

    function automatic logic [63:0] mask_of(input int dw);
        return (dw >= 64) ? '1 : ((64'd1 << dw) - 64'd1);
    endfunction

    // Bit n on the wire, counting from the first bit shifted.
    function automatic logic ref_bit(input logic [63:0] w, input int n, input int dw, input bit lsb);
        return lsb ? w[n] : w[dw-1-n];
    endfunction

    function automatic logic [63:0] get_pdo(input int k);
        case (k)
            0:       return {56'd0, pdo0};
            1:       return {32'd0, pdo1};
            default: return {56'd0, pdo2};
        endcase
    endfunction

    task automatic set_pdi(input int k, input logic [63:0] v);
        case (k)
            0:       pdi0 = v[7:0];
            1:       pdi1 = v[31:0];
            default: pdi2 = v[7:0];
        endcase
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One frame on instance k; send held for `hold` cycles, optional extra
    // one-cycle send pulse at cycle pulse2 (lands mid-frame).
    task automatic run_xfer(input int k, input logic [63:0] pdi, input logic [63:0] rxw,
                            input bit lp, input int hold, input int pulse2,
                            input logic [63:0] exp_pdo, input int exp_cs, input string tag);
        int          dw, hp, window, cs_low, rises, dv_cnt, busy_bad;
        bit          lsb, prev_sck;
        logic        cs_at_dv;
        logic [63:0] seq, exp_seq, got_pdo;
        dw = dw_of(k); hp = hp_of(k); lsb = lsb_of(k);
        window = hp * (2 * dw + 2) + hold + pulse2 + 16;
        cs_low = 0; rises = 0; dv_cnt = 0; busy_bad = 0; prev_sck = 1'b0;
        cs_at_dv = 1'b0; seq = '0; exp_seq = '0; got_pdo = '0;
        set_pdi(k, pdi);
        loop_v[k]  = lp;
        sdi_mdl[k] = ref_bit(rxw, 0, dw, lsb);
        send_v[k]  = 1'b1;
        for (int c = 0; c < window; c++) begin
            @(negedge sclk);
            if (!cs_v[k]) cs_low++;
            if (busy_v[k] !== ~cs_v[k]) busy_bad++;
            if (sck_v[k] && !prev_sck) begin
                if (rises < 64) seq[rises] = sdo_v[k];
                rises++;
            end
            prev_sck = sck_v[k];
            if (dv_v[k]) begin
                dv_cnt++;
                got_pdo  = get_pdo(k);
                cs_at_dv = cs_v[k];
            end
            sdi_mdl[k] = (rises < dw) ? ref_bit(rxw, rises, dw, lsb) : 1'b0;
            if (c + 1 == hold) send_v[k] = 1'b0;
            if (pulse2 > 0 && c + 1 == pulse2) send_v[k] = 1'b1;
            if (pulse2 > 0 && c + 1 == pulse2 + 1) send_v[k] = 1'b0;
        end
        for (int i = 0; i < dw; i++) exp_seq[i] = ref_bit(pdi, i, dw, lsb);
        check($sformatf("%s cs_low_cycles", tag), cs_low, exp_cs);
        check($sformatf("%s spi_clk_rises", tag), rises, dw);
        check($sformatf("%s sdo_sequence", tag), seq, exp_seq);
        check($sformatf("%s data_valid_cycles", tag), dv_cnt, 1);
        check($sformatf("%s pdo_at_valid", tag), got_pdo, exp_pdo);
        check($sformatf("%s cs_high_at_valid", tag), cs_at_dv, 1);
        check($sformatf("%s busy_vs_cs_bad", tag), busy_bad, 0);
        check($sformatf("%s pdo_holds", tag), get_pdo(k), exp_pdo);
        check($sformatf("%s sdo_idle", tag), sdo_v[k], 0);
    endtask

    typedef struct {
        int          k;
        logic [63:0] pdi;
        logic [63:0] rxw;
        bit          lp;
        int          hold;
        int          pulse2;
        logic [63:0] exp_pdo;
        int          exp_cs;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int          rises, dv_cnt, gap, cs_low;
        bit          prev_sck;
        logic [63:0] got;

        tbl[0] = '{0, 64'hA5,       64'h0,        1'b1, 1,   0,  64'hA5,       36};
        tbl[1] = '{1, 64'hDEADBEEF, 64'h12345678, 1'b0, 1,   0,  64'h12345678, 66};
        tbl[2] = '{2, 64'h01,       64'h0,        1'b1, 1,   0,  64'h01,       54};
        tbl[3] = '{0, 64'h3C,       64'h5A,       1'b0, 100, 0,  64'h5A,       36};
        tbl[4] = '{0, 64'hC3,       64'h81,       1'b0, 1,   12, 64'h81,       36};

        reset = 1'b1; send_v = '0; loop_v = '0; sdi_mdl = '0;
        pdi0 = '0; pdi1 = '0; pdi2 = '0;
        repeat (3) @(negedge sclk);
        for (int k = 0; k < NK; k++) begin
            check($sformatf("reset k%0d cs", k), cs_v[k], 1);
            check($sformatf("reset k%0d spi_clk", k), sck_v[k], 0);
            check($sformatf("reset k%0d sdo", k), sdo_v[k], 0);
            check($sformatf("reset k%0d data_valid", k), dv_v[k], 0);
            check($sformatf("reset k%0d busy", k), busy_v[k], 0);
            check($sformatf("reset k%0d pdo", k), get_pdo(k), 0);
        end
        reset = 1'b0;
        repeat (2) @(negedge sclk);

        for (int i = 0; i < 5; i++)
            run_xfer(tbl[i].k, tbl[i].pdi, tbl[i].rxw, tbl[i].lp, tbl[i].hold,
                     tbl[i].pulse2, tbl[i].exp_pdo, tbl[i].exp_cs, $sformatf("vec%0d", i));

        // Abort with reset during bit 3 of 8.
        run_xfer(0, 64'hE7, 64'h0, 1'b1, 1, 0, 64'hE7, 36, "pre_abort");
        set_pdi(0, 64'h3C); loop_v[0] = 1'b1; send_v[0] = 1'b1;
        rises = 0; prev_sck = 1'b0;
        for (int c = 0; c < 200 && rises < 4; c++) begin
            @(negedge sclk);
            send_v[0] = 1'b0;
            if (sck_v[0] && !prev_sck) rises++;
            prev_sck = sck_v[0];
        end
        check("abort reached_bit3", rises, 4);
        reset = 1'b1;
        @(negedge sclk);
        reset = 1'b0;
        check("abort cs", cs_v[0], 1);
        check("abort spi_clk", sck_v[0], 0);
        check("abort busy", busy_v[0], 0);
        check("abort pdo", get_pdo(0), 0);
        dv_cnt = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge sclk);
            if (dv_v[0]) dv_cnt++;
        end
        check("abort no_data_valid", dv_cnt, 0);
        run_xfer(0, 64'h5E, 64'h0, 1'b1, 1, 0, 64'h5E, 36, "post_abort");

        // Back-to-back: re-raise send at the cycle data_valid is seen.
        set_pdi(0, 64'h96); loop_v[0] = 1'b1; send_v[0] = 1'b1;
        dv_cnt = 0; got = '0; gap = 0;
        for (int c = 0; c < 100 && dv_cnt == 0; c++) begin
            @(negedge sclk);
            send_v[0] = 1'b0;
            if (dv_v[0]) begin
                dv_cnt++;
                got = get_pdo(0);
                if (cs_v[0]) gap++;
            end
        end
        check("b2b first_valid", dv_cnt, 1);
        check("b2b first_pdo", got, 64'h96);
        set_pdi(0, 64'h69); send_v[0] = 1'b1;
        @(negedge sclk);
        send_v[0] = 1'b0;
        check("b2b second_start_cs", cs_v[0], 0);
        check("b2b second_start_busy", busy_v[0], 1);
        check("b2b cs_gap_ok", (gap >= 1), 1);
        cs_low = 1; dv_cnt = 0; got = '0;
        for (int c = 0; c < 100 && dv_cnt == 0; c++) begin
            @(negedge sclk);
            if (!cs_v[0]) cs_low++;
            if (dv_v[0]) begin
                dv_cnt++;
                got = get_pdo(0);
            end
        end
        check("b2b second_valid", dv_cnt, 1);
        check("b2b second_pdo", got, 64'h69);
        check("b2b second_cs_low", cs_low, 36);
        repeat (2) @(negedge sclk);

        // Randomized frames checked against the word-level reference.
        for (int i = 0; i < 30; i++) begin
            int          k, hold, pulse2, dw;
            bit          lp;
            logic [63:0] pdi, rxw, exp;
            k      = $urandom_range(0, NK - 1);
            dw     = dw_of(k);
            pdi    = {$urandom, $urandom} & mask_of(dw);
            rxw    = {$urandom, $urandom} & mask_of(dw);
            lp     = $urandom_range(0, 1);
            hold   = $urandom_range(1, 4);
            pulse2 = ($urandom_range(0, 1) != 0) ? $urandom_range(6, 20) : 0;
            exp    = lp ? pdi : rxw;
            run_xfer(k, pdi, rxw, lp, hold, pulse2, exp, hp_of(k) * (2 * dw + 2),
                     $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
